// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared mode codes, FSM encoding and initial LED patterns
package led_ctrl_pkg;
    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_CHASE  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;
    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [3:0] PAT_OFF  = 4'b0000;
    localparam logic [3:0] PAT_SEED = 4'b0001;
    localparam logic [3:0] PAT_ALL  = 4'b1111;
    function automatic logic [3:0] init_pattern(input logic [1:0] mode);
        return mode == MODE_BLINK ? PAT_ALL : mode == MODE_OFF ? PAT_OFF : PAT_SEED;
    endfunction
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: step-period divider producing a one-cycle clock-enable tick
module led_tick_gen (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] period,
    output logic        tick
);
    logic [31:0] count_q, count_d;
    // >= rather than == so a period shortened mid-count still wraps promptly
    assign tick = en && (count_q >= period - 32'd1);
    // count only while enabled; clear on request or on reaching the terminal count
    always_comb count_d = clr ? 32'd0 : !en ? count_q : tick ? 32'd0 : count_q + 32'd1;
    // counter register
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) count_q <= 32'd0;
        else       count_q <= count_d;
endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: command-driven sequencer for CHASE/BOUNCE/BLINK/OFF LED patterns
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1250000,
    parameter int unsigned N_LED    = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [1:0]       cmd_speed,
    input  logic             pause,
    output logic [N_LED-1:0] led,
    output logic             step_strobe
);
    logic [1:0]       state_q, state_d, mode_q, mode_d, speed_q, speed_d;
    logic [N_LED-1:0] led_q, led_d, step_led;
    logic             down_q, down_d, strobe_q, strobe_d, bounce_down, accept, tick;
    logic [31:0]      period;
    assign cmd_ready   = state_q != S_LOAD;
    assign accept      = cmd_valid && cmd_ready;
    assign period      = 32'(TICK_DIV) << speed_q;
    assign led         = led_q;
    assign step_strobe = strobe_q;
    // bounce reverses when the lit LED sits at the end it is heading towards
    assign bounce_down = down_q ? !led_q[0] : led_q[3];
    assign step_led    = mode_q == MODE_CHASE  ? {led_q[2:0], led_q[3]} :
                         mode_q == MODE_BOUNCE ? (bounce_down ? led_q >> 1 : led_q << 1) :
                         ~led_q;
    led_tick_gen u_tick (
        .clk    (clk),
        .nrst   (nrst),
        .en     (state_q == S_RUN && !pause),
        .clr    (state_q == S_LOAD),
        .period (period),
        .tick   (tick)
    );
    // next state: a new command outranks loading and stepping, so a tick on the accept cycle is dropped
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        speed_d  = speed_q;
        led_d    = led_q;
        down_d   = down_q;
        strobe_d = 1'b0;
        if (accept) begin
            state_d = S_LOAD;
            mode_d  = cmd_mode;
            speed_d = cmd_speed;
        end else if (state_q == S_LOAD) begin
            led_d   = init_pattern(mode_q);
            down_d  = 1'b0;
            state_d = mode_q == MODE_OFF ? S_OFF : S_RUN;
        end else if (tick) begin
            led_d    = step_led;
            down_d   = bounce_down;
            strobe_d = 1'b1;
        end
    end
    // state registers; the strobe is registered so it coincides with the stepped led value
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state_q  <= S_OFF;
            mode_q   <= MODE_OFF;
            speed_q  <= 2'd0;
            led_q    <= '0;
            down_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            speed_q  <= speed_d;
            led_q    <= led_d;
            down_q   <= down_d;
            strobe_q <= strobe_d;
        end
endmodule
